// File: rtl/hamming_decoder_21_16_if.sv
// Stream bundle for the Hamming (21,16) decoder: codeword input side and decoded output side.
interface hamming_decoder_21_16_if;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_corrected;
  logic        out_uncorrectable;
  logic [4:0]  out_syndrome;

  // Environment view: supplies codewords and acts as the output sink.
  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_syndrome
  );

  // Decoder view.
  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_syndrome
  );
endinterface

// File: rtl/hamming_decoder_21_16.sv
// Hamming (21,16) SEC decoder, 2-stage valid/ready pipeline with full throughput.
// Optional saturating error counters are built when HAMMING_DEC_ERR_CNT_EN is defined.
module hamming_decoder_21_16 #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hamming_decoder_21_16_if.slave bus,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      corr_cnt,
  output logic [CNT_W-1:0]      uncorr_cnt
);

  // Bit k of the syndrome covers every code position (index+1) with bit k set.
  function automatic logic [4:0] calc_syndrome(input logic [20:0] code);
    logic [4:0] syn;
    syn = '0;
    for (int i = 0; i < 21; i++) begin
      for (int k = 0; k < 5; k++) begin
        if (((i + 1) >> k) & 1) syn[k] = syn[k] ^ code[i];
      end
    end
    return syn;
  endfunction

  function automatic logic [20:0] correct_code(input logic [20:0] code, input logic [4:0] syn);
    logic [20:0] fixed;
    fixed = code;
    for (int i = 0; i < 21; i++) begin
      if (syn == 5'(i + 1)) fixed[i] = ~fixed[i];
    end
    return fixed;
  endfunction

  function automatic logic [15:0] extract_data(input logic [20:0] code);
    return {code[20:16], code[14:8], code[6:4], code[2]};
  endfunction

  logic [20:0] code_p1;
  logic [4:0]  syn_p1;
  logic        vld_p1;
  logic [15:0] data_p2;
  logic [4:0]  syn_p2;
  logic        corr_p2;
  logic        uncorr_p2;
  logic        vld_p2;
  logic        s1_moves;
  logic        accept;
  logic        out_fire;
  logic        syn_correctable;

  assign s1_moves        = vld_p1 && (!vld_p2 || bus.out_ready);
  assign bus.in_ready    = !vld_p1 || s1_moves;
  assign accept          = bus.in_valid && bus.in_ready;
  assign out_fire        = vld_p2 && bus.out_ready;
  assign syn_correctable = (syn_p1 != 5'd0) && (syn_p1 <= 5'd21);

  // Stage 1: capture codeword and its syndrome
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      code_p1 <= '0;
      syn_p1  <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      code_p1 <= bus.in_code;
      syn_p1  <= calc_syndrome(bus.in_code);
    end else if (s1_moves) begin
      vld_p1  <= 1'b0;
    end
  end

  // Stage 2: correct, extract and hold until the sink takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      data_p2   <= '0;
      syn_p2    <= '0;
      corr_p2   <= 1'b0;
      uncorr_p2 <= 1'b0;
    end else if (s1_moves) begin
      vld_p2    <= 1'b1;
      data_p2   <= syn_correctable ? extract_data(correct_code(code_p1, syn_p1))
                                   : extract_data(code_p1);
      syn_p2    <= syn_p1;
      corr_p2   <= syn_correctable;
      uncorr_p2 <= (syn_p1 >= 5'd22);
    end else if (bus.out_ready) begin
      vld_p2    <= 1'b0;
    end
  end

  assign bus.out_valid         = vld_p2;
  assign bus.out_data          = data_p2;
  assign bus.out_syndrome      = syn_p2;
  assign bus.out_corrected     = corr_p2;
  assign bus.out_uncorrectable = uncorr_p2;

`ifdef HAMMING_DEC_ERR_CNT_EN
  logic [CNT_W-1:0] corr_q;
  logic [CNT_W-1:0] uncorr_q;

  // Clear has priority over a same-cycle count; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (cnt_clr) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      if (out_fire && corr_p2 && (corr_q != '1))     corr_q   <= corr_q + 1'b1;
      if (out_fire && uncorr_p2 && (uncorr_q != '1)) uncorr_q <= uncorr_q + 1'b1;
    end
  end

  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;
`else
  logic cnt_clr_unused;
  logic out_fire_unused;

  assign cnt_clr_unused  = cnt_clr;
  assign out_fire_unused = out_fire;
  assign corr_cnt        = '0;
  assign uncorr_cnt      = '0;
`endif

endmodule

// File: doc/hamming_decoder_21_16.md
Name: hamming_decoder_21_16

Overview:
Hamming (21,16) single-error-correcting decoder. It sits downstream of the 16-bit Hamming coder and consumes its 21-bit codewords after the channel or storage path. The block computes the 5-bit syndrome, corrects any single-bit error and extracts the 16 data bits. It is a 2-stage valid/ready pipeline with full throughput and backpressure, so it can be used in the power-evaluation flow with a throttled sink.

Parameters:
CNT_W, 16, width of the saturating error-statistics counters (used only when the optional feature is compiled in).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  in_code is valid this cycle.
in_ready  output  1  decoder accepts in_code this cycle.
in_code  input  21  codeword; bit i is Hamming position i+1.
out_valid  output  1  out_* fields are valid.
out_ready  input  1  sink accepts the output this cycle.
out_data  output  16  corrected data word.
out_corrected  output  1  a single-bit error was corrected (data bit or parity bit).
out_uncorrectable  output  1  syndrome is 22..31; no position exists for it.
out_syndrome  output  5  raw syndrome, for debug.
cnt_clr  input  1  synchronous clear of the statistics counters.
corr_cnt  output  CNT_W  count of corrected words.
uncorr_cnt  output  CNT_W  count of uncorrectable words.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both stage-valid flags clear; out_valid=0.
  - out_data, out_syndrome, out_corrected, out_uncorrectable = 0; counters = 0.
  - in_ready=1 once reset is released.
- Codeword map:
  - Parity bits at indices 0, 1, 3, 7, 15.
  - data[0] at index 2; data[3:1] at 6:4; data[10:4] at 14:8; data[15:11] at 20:16.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - in_ready = !s1_valid || s1_moves. s1_moves = s1_valid && (!s2_valid || out_ready).
  - out_valid = s2_valid.
  - The output is held stable while out_valid && !out_ready.
  - No combinational path from in_valid to out_valid; in_ready may depend combinationally on out_ready.
- Stage 1: registers in_code and computes syndrome S. S[k] = XOR of in_code[i] for all i where bit k of (i+1) is 1, k=0..4.
- Stage 2: registers the outputs.
  - S=0: data is extracted unchanged; corrected=0, uncorrectable=0.
  - S=1..21: invert code bit S-1, then extract; corrected=1. S in {1,2,4,8,16} means a parity-bit error, so data is unchanged but corrected is still 1.
  - S=22..31: extract raw data without correction; uncorrectable=1, corrected=0.
- Latency and throughput:
  - Output valid 2 cycles after acceptance with no backpressure.
  - One word per cycle sustained.
  - Order is preserved; no word is dropped or duplicated under any out_ready pattern.
- Simultaneous events: stage 2 emitting and refilling on the same edge is legal; stage 1 accepting while moving to stage 2 is legal.
- Reset mid-operation flushes both stages; in-flight words are discarded with no output.
- Multi-bit errors: 2+ bit errors may alias to a legal S and miscorrect silently; this is accepted behaviour for SEC-only.

Optional Feature:
HAMMING_DEC_ERR_CNT_EN
- Defined:
  - corr_cnt increments on each output transfer with out_corrected=1.
  - uncorr_cnt increments on each output transfer with out_uncorrectable=1.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr zeroes both counters. If cnt_clr coincides with a counting transfer, clear wins.
- Undefined: counter logic is not built; corr_cnt and uncorr_cnt are tied to 0; cnt_clr is ignored. Ports are present in both builds.

Test Plan:
1. in_code=0x000000, out_ready=1 -> 2 cycles later out_data=0x0000, S=0, corrected=0, uncorrectable=0.
2. in_code=0x1FFFFE (clean codeword for 0xFFFF) -> out_data=0xFFFF, S=0. Then in_code=0x1FFFDE (bit 5 flipped) -> S=6, out_data=0xFFFF, corrected=1.
3. in_code=0x000080 (parity bit 7 flipped) -> S=8, out_data=0x0000, corrected=1. With counters built, corr_cnt=1.
4. in_code=0x100002 (bits 20 and 1 flipped) -> S=23, uncorrectable=1, out_data=0x8000 (raw). With counters built, uncorr_cnt=1.
5. Stream 20 back-to-back words with random out_ready (50%) -> outputs in order and bit-exact against the reference model. in_ready drops only when both stages are full; throughput is 1/cycle when out_ready=1.
6. Assert rst_n low with both stages full and out_ready=0 -> out_valid=0 immediately and counters=0. After release, the next word decodes normally with 2-cycle latency.
